dm_trigger_core: RTL and testbench
==================================

# dm_trigger_core

Parametrised multi-channel trigger unit for the dark-matter readout path, successor to the fixed four-lane, 16-bit trigger in `top`. It does the following:
- registers NUM_CH receiver lanes;
- flags lanes whose sample exceeds a threshold;
- fires a trigger when at least COINC lanes hit in the same cycle and a BRAM buffer is ready;
- holds `triggering_status` until the DRAM read handshake completes, then applies a hold-off.

It sits between the transceiver parallel-data outputs and the BRAM/DRAM capture logic.

## Interface
Parameters:
- NUM_CH, 4, number of receiver lanes (1..16)
- DATA_W, 16, bits per lane sample
- NUM_BRAM, 8, number of capture BRAMs (2..32)
- THRESH, 20, unsigned hit threshold; a lane hits when sample > THRESH
- COINC, 1, minimum simultaneous hit lanes to trigger (1..NUM_CH)
- HOLDOFF, 4, dead cycles after DRAM handshake (0..255)
- TIMEOUT, 1024, max cycles to wait for DRAM_Read_Valid (≥1)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-low reset
- rx_parallel_data  in  NUM_CH*DATA_W  lane i at [i*DATA_W +: DATA_W]
- BRAM_ready_mask  in  NUM_BRAM  bit b = BRAM b ready to capture
- DRAM_Read_Valid  in  1  DRAM read of the captured buffer accepted
- triggering_status  out  1  trigger outstanding (awaiting DRAM handshake)
- trig_bram_sel  out  $clog2(NUM_BRAM)  BRAM chosen at trigger
- trig_chan_hits  out  NUM_CH  hit vector latched at trigger
- trig_count  out  16  accepted triggers, saturating at 0xFFFF
- missed_count  out  16  qualifying events not accepted, saturating
- timeout_pulse  out  1  one-cycle pulse on DRAM wait timeout
- trig_timestamp  out  32  free-running cycle count latched at trigger

## Operation
- Stage 1: `rx_parallel_data` is registered every cycle into `samp_q`.
- Hit vector: hit[i] = samp_q lane i > THRESH, unsigned compare, combinational.
- Qualifying event: popcount(hit) ≥ COINC.
- Reset (rst=0 at an edge) clears all outputs, counters, timestamp and `samp_q` to 0 and sets the state to IDLE. Reset mid-operation abandons any outstanding trigger with no pulse.
- IDLE, qualifying event and |BRAM_ready_mask=1:
  - go to WAIT_DRAM;
  - latch trig_chan_hits=hit;
  - trig_bram_sel = lowest set bit index of BRAM_ready_mask;
  - trig_count++;
  - latch the timestamp.
- IDLE, qualifying event and mask=0: missed_count++ and stay in IDLE.
- IDLE, DRAM_Read_Valid: ignored.
- WAIT_DRAM, DRAM_Read_Valid=1:
  - go to HOLDOFF with the down-counter loaded to HOLDOFF;
  - if HOLDOFF=0, go directly to IDLE.
- WAIT_DRAM, wait counter reaches TIMEOUT cycles without DRAM_Read_Valid: go to IDLE and pulse timeout_pulse for 1 cycle.
- WAIT_DRAM and HOLDOFF: each qualifying event increments missed_count.
- HOLDOFF: decrement each cycle; when the counter equals 1, go to IDLE on that edge (exactly HOLDOFF cycles in HOLDOFF).
- triggering_status = (state == WAIT_DRAM), registered.
- trig_bram_sel and trig_chan_hits hold their values until the next accepted trigger.
- Counters saturate and never wrap. The 32-bit timestamp wraps naturally.

## Timing
- Latency: a sample presented before edge N is registered at edge N and evaluated between N and N+1. triggering_status rises after edge N+1 (2 edges).
- DRAM_Read_Valid is not registered. When it is high at edge M in WAIT_DRAM, triggering_status is low after edge M.
- In IDLE, a trigger and DRAM_Read_Valid in the same cycle: the trigger is taken and DRAM_Read_Valid is ignored. The handshake must arrive while in WAIT_DRAM.
- In WAIT_DRAM, DRAM_Read_Valid in the same cycle as the timeout: the handshake wins and no timeout_pulse is generated.
- The earliest re-trigger is HOLDOFF+1 edges after the handshake edge.
- BRAM_ready_mask is sampled only at the trigger-decision edge.

## Configuration
- DM_TRIG_TIMESTAMP_EN defined: a 32-bit free-running counter increments every cycle after reset. Its value at the trigger edge is latched into trig_timestamp.
- DM_TRIG_TIMESTAMP_EN undefined: no counter is built and trig_timestamp is tied to 0.
- All other behaviour is identical with or without the macro.

## Test plan
All scenarios use default parameters.
- Reset then idle: hold rst=0 for 10 cycles with lanes=16,17,18,19, then release. All outputs stay 0 and triggering_status stays 0.
- Basic trigger: set mask=8'b00000001, drive lane0=21 for 1 cycle, then pulse DRAM_Read_Valid.
  - triggering_status rises 2 edges after the sample.
  - trig_bram_sel=0, trig_chan_hits=4'b0001, trig_count=1.
  - triggering_status falls on the DRAM_Read_Valid edge.
- BRAM select and miss: first drive mask=0 and lane2=30, giving missed_count=1 and no trigger. Then set mask=8'b00101000 and repeat the event, giving trig_bram_sel=3 and trig_chan_hits=4'b0100.
- Hold-off:
  - Trigger, then handshake.
  - Drive qualifying samples continuously.
  - The next trigger lands 5 edges after the handshake.
  - Events evaluated in WAIT_DRAM and HOLDOFF increment missed_count.
- Coincidence and timeout:
  - With COINC=2, a lone lane1=25 does not trigger; lane1=25 together with lane3=40 does.
  - Withhold DRAM_Read_Valid for 1024 cycles: timeout_pulse fires once and the state returns to IDLE.
  - Repeat with DRAM_Read_Valid asserted on the timeout cycle: no pulse.
- Reset mid-WAIT_DRAM: triggering_status clears on the reset edge and the counters return to 0. Check trig_timestamp with and without DM_TRIG_TIMESTAMP_EN (equals the cycle count at the trigger edge vs. 0).

Source files
------------

// File: rtl/dm_trigger_core.sv
// dm_trigger_core: multi-lane threshold/coincidence trigger with DRAM handshake, timeout and hold-off.
// Optional feature: define DM_TRIG_TIMESTAMP_EN to build the free-running 32-bit timestamp
// latched into trig_timestamp; without it trig_timestamp is tied to 0.
module dm_trigger_core #(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = 16,
   parameter int NUM_BRAM = 8,
   parameter int THRESH   = 20,
   parameter int COINC    = 1,
   parameter int HOLDOFF  = 4,
   parameter int TIMEOUT  = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH*DATA_W-1:0]    rx_parallel_data,
   input  logic [NUM_BRAM-1:0]         BRAM_ready_mask,
   input  logic                        DRAM_Read_Valid,
   output logic                        triggering_status,
   output logic [$clog2(NUM_BRAM)-1:0] trig_bram_sel,
   output logic [NUM_CH-1:0]           trig_chan_hits,
   output logic [15:0]                 trig_count,
   output logic [15:0]                 missed_count,
   output logic                        timeout_pulse,
   output logic [31:0]                 trig_timestamp
);
   localparam int SEL_W = $clog2(NUM_BRAM);
   localparam logic [DATA_W-1:0] THR = DATA_W'(THRESH);

   typedef enum logic [1:0] {IDLE, WAIT_DRAM, HOLD} state_t;

   state_t                  state_q;
   logic [NUM_CH*DATA_W-1:0] samp_q;
   logic                    status_q, pulse_q;
   logic [SEL_W-1:0]        sel_q, low_sel;
   logic [NUM_CH-1:0]       hits_q, hit;
   logic [15:0]             trig_cnt_q, miss_cnt_q, trig_cnt_d, miss_cnt_d;
   logic [31:0]             wait_q, trig_ts_q, ts_q;
   logic [7:0]              hold_q;
   logic                    qual, miss_ev;
   int                      pop;

`ifdef DM_TRIG_TIMESTAMP_EN
   // free-running cycle counter, wraps naturally
   always_ff @(posedge clk) ts_q <= !rst ? '0 : ts_q + 32'd1;
`else
   assign ts_q = '0;
`endif

   // per-lane threshold hits and their popcount from the registered samples
   always_comb begin
      hit = '0;
      pop = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i] = samp_q[i*DATA_W +: DATA_W] > THR;
         pop = pop + int'(hit[i]);
      end
   end

   // lowest ready BRAM wins
   always_comb begin
      low_sel = '0;
      for (int b = NUM_BRAM - 1; b >= 0; b--)
         low_sel = BRAM_ready_mask[b] ? SEL_W'(b) : low_sel;
   end

   assign qual       = pop >= COINC;
   assign miss_ev    = qual && (state_q != IDLE || ~|BRAM_ready_mask);
   assign trig_cnt_d = &trig_cnt_q ? trig_cnt_q : trig_cnt_q + 16'd1;
   assign miss_cnt_d = &miss_cnt_q ? miss_cnt_q : miss_cnt_q + 16'd1;

   // trigger FSM: sample register, accept/miss decisions, DRAM wait with timeout, hold-off
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         samp_q     <= '0;
         status_q   <= 1'b0;
         pulse_q    <= 1'b0;
         sel_q      <= '0;
         hits_q     <= '0;
         trig_cnt_q <= '0;
         miss_cnt_q <= '0;
         wait_q     <= '0;
         hold_q     <= '0;
         trig_ts_q  <= '0;
      end else begin
         samp_q  <= rx_parallel_data;
         pulse_q <= 1'b0;
         if (miss_ev) miss_cnt_q <= miss_cnt_d;
         case (state_q)
            IDLE: begin
               if (qual && |BRAM_ready_mask) begin
                  state_q    <= WAIT_DRAM;
                  status_q   <= 1'b1;
                  hits_q     <= hit;
                  sel_q      <= low_sel;
                  trig_cnt_q <= trig_cnt_d;
                  trig_ts_q  <= ts_q;
                  wait_q     <= '0;
               end
            end
            WAIT_DRAM: begin
               if (DRAM_Read_Valid) begin
                  state_q  <= (HOLDOFF == 0) ? IDLE : HOLD;
                  status_q <= 1'b0;
                  hold_q   <= 8'(HOLDOFF);
               end else if (wait_q == 32'(TIMEOUT - 1)) begin
                  state_q  <= IDLE;
                  status_q <= 1'b0;
                  pulse_q  <= 1'b1;
               end else begin
                  wait_q <= wait_q + 32'd1;
               end
            end
            HOLD: begin
               state_q <= (hold_q == 8'd1) ? IDLE : HOLD;
               hold_q  <= hold_q - 8'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign triggering_status = status_q;
   assign trig_bram_sel     = sel_q;
   assign trig_chan_hits    = hits_q;
   assign trig_count        = trig_cnt_q;
   assign missed_count      = miss_cnt_q;
   assign timeout_pulse     = pulse_q;
   assign trig_timestamp    = trig_ts_q;
endmodule

// File: tb/tb_dm_trigger_core.sv
// tb_dm_trigger_core: directed bench for dm_trigger_core (main instance COINC=1, second instance COINC=2).
module tb_dm_trigger_core;
   logic        clk = 1'b0, rst = 1'b0, drv = 1'b0;
   logic [63:0] rx = '0;
   logic [7:0]  mask = '0;
   logic        st, pl, st2, pl2;
   logic [2:0]  sel, sel2;
   logic [3:0]  hits, hits2;
   logic [15:0] tc, mc, tc2, mc2;
   logic [31:0] ts, ts2, cyc;
   int          n_cmp = 0, n_err = 0;
   int          bad_st, bad_pl;

   dm_trigger_core u_dut (
      .clk(clk), .rst(rst), .rx_parallel_data(rx), .BRAM_ready_mask(mask),
      .DRAM_Read_Valid(drv), .triggering_status(st), .trig_bram_sel(sel),
      .trig_chan_hits(hits), .trig_count(tc), .missed_count(mc),
      .timeout_pulse(pl), .trig_timestamp(ts));

   dm_trigger_core #(.COINC(2)) u_dut2 (
      .clk(clk), .rst(rst), .rx_parallel_data(rx), .BRAM_ready_mask(mask),
      .DRAM_Read_Valid(drv), .triggering_status(st2), .trig_bram_sel(sel2),
      .trig_chan_hits(hits2), .trig_count(tc2), .missed_count(mc2),
      .timeout_pulse(pl2), .trig_timestamp(ts2));

   always #5 clk = ~clk;

   // reference cycle counter for the expected timestamp
   always @(posedge clk) cyc <= !rst ? 32'd0 : cyc + 32'd1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lanes(input int l0, input int l1, input int l2, input int l3);
      rx = {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_ts(input logic [31:0] c);
`ifdef DM_TRIG_TIMESTAMP_EN
      return c - 32'd1;
`else
      return 32'd0 & c;
`endif
   endfunction

   initial begin
      // reset held with sub-threshold lanes
      lanes(16, 17, 18, 19);
      repeat (10) tick();
      chk("rst_status", st, 0);
      chk("rst_trig_count", tc, 0);
      chk("rst_missed", mc, 0);
      chk("rst_sel", sel, 0);
      chk("rst_hits", hits, 0);
      chk("rst_pulse", pl, 0);
      chk("rst_ts", ts, 0);
      rst = 1'b1;
      repeat (3) tick();
      chk("idle_status", st, 0);
      chk("idle_trig_count", tc, 0);
      chk("idle_missed", mc, 0);

      // basic trigger, lane0 = 21
      mask = 8'b0000_0001;
      lanes(21, 0, 0, 0);
      tick();
      lanes(0, 0, 0, 0);
      chk("lat_1edge_status", st, 0);
      tick();
      chk("lat_2edge_status", st, 1);
      chk("basic_sel", sel, 0);
      chk("basic_hits", hits, 4'b0001);
      chk("basic_trig_count", tc, 1);
      chk("basic_missed", mc, 0);
      chk("basic_ts", ts, exp_ts(cyc));
      repeat (2) tick();
      chk("wait_status_held", st, 1);
      drv = 1'b1;
      tick();
      drv = 1'b0;
      chk("handshake_fall", st, 0);
      repeat (5) tick();

      // miss with empty mask, then lowest-ready select
      mask = 8'h00;
      lanes(0, 0, 30, 0);
      tick();
      lanes(0, 0, 0, 0);
      tick();
      chk("miss_count", mc, 1);
      chk("miss_status", st, 0);
      chk("miss_trig_count", tc, 1);
      mask = 8'b0010_1000;
      lanes(0, 0, 30, 0);
      tick();
      lanes(0, 0, 0, 0);
      tick();
      chk("sel_status", st, 1);
      chk("sel_bram", sel, 3);
      chk("sel_hits", hits, 4'b0100);
      chk("sel_trig_count", tc, 2);
      drv = 1'b1;
      tick();
      drv = 1'b0;
      repeat (5) tick();

      // hold-off with continuous qualifying samples
      mask = 8'b0000_0001;
      lanes(21, 0, 0, 0);
      tick();
      chk("ho_pre_status", st, 0);
      tick();
      chk("ho_trig_status", st, 1);
      chk("ho_trig_count", tc, 3);
      drv = 1'b1;
      tick();
      drv = 1'b0;
      chk("ho_hs_status", st, 0);
      chk("ho_hs_missed", mc, 2);
      bad_st = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (st !== 1'b0) bad_st++;
      end
      chk("ho_dead_status", bad_st, 0);
      chk("ho_dead_missed", mc, 6);
      lanes(0, 0, 0, 0);
      tick();
      chk("ho_retrig_status", st, 1);
      chk("ho_retrig_count", tc, 4);
      chk("ho_retrig_missed", mc, 6);
      drv = 1'b1;
      tick();
      drv = 1'b0;
      chk("ho_hs2_missed", mc, 6);
      repeat (5) tick();

      // idle handshake ignored; trigger and handshake together: trigger wins
      drv = 1'b1;
      tick();
      chk("idle_drv_status", st, 0);
      drv = 1'b0;
      lanes(21, 0, 0, 0);
      tick();
      lanes(0, 0, 0, 0);
      drv = 1'b1;
      tick();
      drv = 1'b0;
      chk("trig_drv_status", st, 1);
      chk("trig_drv_count", tc, 5);
      chk("trig_drv_ts", ts, exp_ts(cyc));

      // timeout with DRAM_Read_Valid withheld
      bad_st = 0;
      bad_pl = 0;
      for (int k = 1; k < 1024; k++) begin
         tick();
         if (st !== 1'b1) bad_st++;
         if (pl !== 1'b0) bad_pl++;
      end
      chk("to_wait_status", bad_st, 0);
      chk("to_wait_pulse", bad_pl, 0);
      tick();
      chk("to_status", st, 0);
      chk("to_pulse", pl, 1);
      tick();
      chk("to_pulse_once", pl, 0);
      repeat (3) tick();

      // handshake on the timeout cycle wins
      lanes(21, 0, 0, 0);
      tick();
      lanes(0, 0, 0, 0);
      tick();
      chk("to2_status", st, 1);
      chk("to2_trig_count", tc, 6);
      repeat (1023) tick();
      chk("to2_last_status", st, 1);
      drv = 1'b1;
      tick();
      drv = 1'b0;
      chk("to2_hs_status", st, 0);
      chk("to2_hs_pulse", pl, 0);
      tick();
      chk("to2_after_pulse", pl, 0);
      repeat (5) tick();

      // coincidence on the COINC=2 instance
      lanes(0, 25, 0, 0);
      tick();
      lanes(0, 0, 0, 0);
      tick();
      chk("coinc_lone_status", st2, 0);
      chk("coinc_lone_count", tc2, 0);
      chk("coinc_main_status", st, 1);
      drv = 1'b1;
      tick();
      drv = 1'b0;
      repeat (5) tick();
      lanes(0, 25, 0, 40);
      tick();
      lanes(0, 0, 0, 0);
      tick();
      chk("coinc_pair_status", st2, 1);
      chk("coinc_pair_hits", hits2, 4'b1010);
      chk("coinc_pair_count", tc2, 1);
      chk("coinc_main_count", tc, 8);

      // reset in WAIT_DRAM
      rst = 1'b0;
      tick();
      chk("mid_rst_status", st, 0);
      chk("mid_rst_status2", st2, 0);
      chk("mid_rst_trig_count", tc, 0);
      chk("mid_rst_missed", mc, 0);
      chk("mid_rst_pulse", pl, 0);
      chk("mid_rst_hits", hits, 0);
      chk("mid_rst_ts", ts, 0);
      rst = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
